avalon_mem_arbiter: RTL and testbench

AVALON_MEM_ARBITER -- requirements
Module: avalon_mem_arbiter

---
 rtl/avalon_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_avalon_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter
//   Shares one Avalon-MM master between an instruction fetch port (read only)
//   and a data port (read/write, byte enables). One transaction at a time.
//   The winning request is latched, so a requester may change or drop its
//   inputs after the grant without disturbing the transaction in flight.
//   Misaligned addresses (address[1:0] != 0) complete at once with err and
//   issue no bus cycle.
// Parameters
//   ROUND_ROBIN  0: the data port always wins; 1: alternate the ports on contention
// Ports
//   clk, reset                       clock, asynchronous active-low reset
//   i_read, i_address                instruction request, held until i_done
//   i_readdata, i_done               instruction result word, one-cycle completion
//   d_read, d_write, d_address,
//   d_writedata, d_byteenable        data request, held until d_done
//   d_readdata, d_done               data result word, one-cycle completion
//   err                              pulses with done for a misaligned request
//   avm_*                            Avalon-MM master (read latency 1)
module avalon_mem_arbiter #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_readdata,
  output logic        i_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_done,
  output logic        err,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_address,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        port_q, port_d;      // 1 = data port owns the transaction
  logic        mis_q, mis_d;
  logic        last_d_q, last_d_d;  // 1 = data port was granted last
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        req_i_s;
  logic        req_d_s;
  logic        req_any_s;
  logic        gnt_d_s;
  logic [31:0] sel_addr_s;
  logic        sel_mis_s;
  logic        bus_s;
  logic        done_s;

  assign req_i_s   = i_read;
  assign req_d_s   = d_read | d_write;
  assign req_any_s = req_i_s | req_d_s;
  // Data wins unless round-robin is enabled, the instruction port is also
  // asking, and data had the previous grant.
  assign gnt_d_s    = req_d_s & (~RR_EN | ~req_i_s | ~last_d_q);
  assign sel_addr_s = gnt_d_s ? d_address : i_address;
  assign sel_mis_s  = (sel_addr_s[1:0] != 2'b00);

  // Next-state and datapath capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    wr_d      = wr_q;
    port_d    = port_q;
    mis_d     = mis_q;
    last_d_d  = last_d_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      // DONE arbitrates like IDLE so that a waiting port is granted on the
      // edge that ends the previous transaction. The finishing requester
      // drops its request once it sees its done pulse.
      IDLE, DONE: begin
        if (req_any_s) begin
          addr_d   = sel_addr_s;
          wdata_d  = gnt_d_s ? d_writedata : 32'h0000_0000;
          be_d     = gnt_d_s ? d_byteenable : 4'b1111;
          wr_d     = gnt_d_s & d_write;
          port_d   = gnt_d_s;
          mis_d    = sel_mis_s;
          last_d_d = gnt_d_s;
          state_d  = sel_mis_s ? DONE : BUS;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (!avm_waitrequest) begin
          state_d = wr_q ? DONE : RDATA;
        end else begin
          state_d = BUS;
        end
      end
      RDATA: begin
        if (port_q) begin
          d_rdata_d = avm_readdata;
        end else begin
          i_rdata_d = avm_readdata;
        end
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      be_q      <= 4'b0000;
      wr_q      <= 1'b0;
      port_q    <= 1'b0;
      mis_q     <= 1'b0;
      last_d_q  <= 1'b1;
      i_rdata_q <= 32'h0000_0000;
      d_rdata_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      wr_q      <= wr_d;
      port_q    <= port_d;
      mis_q     <= mis_d;
      last_d_q  <= last_d_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Every output decodes registered state only; bus outputs are zero outside
  // BUS, so reset clears them without waiting for a clock.
  assign bus_s  = (state_q == BUS);
  assign done_s = (state_q == DONE);

  assign avm_read       = bus_s & ~wr_q;
  assign avm_write      = bus_s & wr_q;
  assign avm_address    = bus_s ? addr_q : 32'h0000_0000;
  assign avm_writedata  = bus_s ? wdata_q : 32'h0000_0000;
  assign avm_byteenable = bus_s ? be_q : 4'b0000;

  assign i_done     = done_s & ~port_q;
  assign d_done     = done_s & port_q;
  assign err        = done_s & mis_q;
  assign i_readdata = i_rdata_q;
  assign d_readdata = d_rdata_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter: dut0 (fixed priority) drives a
// memory slave with programmable wait states; dut1 (round robin) drives a
// zero-wait slave. Expected completions are queued when a request is issued
// and compared when the done pulse appears.
module tb_avalon_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // dut0 signals
  logic        i_read0, d_read0, d_write0;
  logic [31:0] i_address0, d_address0, d_writedata0;
  logic [3:0]  d_byteenable0;
  logic [31:0] i_readdata0, d_readdata0;
  logic        i_done0, d_done0, err0;
  logic        avm_read0, avm_write0, avm_waitrequest0;
  logic [3:0]  avm_byteenable0;
  logic [31:0] avm_address0, avm_writedata0, avm_readdata0;

  // dut1 signals
  logic        i_read1, d_read1, d_write1;
  logic [31:0] i_address1, d_address1, d_writedata1;
  logic [3:0]  d_byteenable1;
  logic [31:0] i_readdata1, d_readdata1;
  logic        i_done1, d_done1, err1;
  logic        avm_read1, avm_write1, avm_waitrequest1;
  logic [3:0]  avm_byteenable1;
  logic [31:0] avm_address1, avm_writedata1, avm_readdata1;

  avalon_mem_arbiter #(.ROUND_ROBIN(0)) dut0 (
    .clk(clk), .reset(rst_n),
    .i_read(i_read0), .i_address(i_address0), .i_readdata(i_readdata0), .i_done(i_done0),
    .d_read(d_read0), .d_write(d_write0), .d_address(d_address0),
    .d_writedata(d_writedata0), .d_byteenable(d_byteenable0),
    .d_readdata(d_readdata0), .d_done(d_done0), .err(err0),
    .avm_read(avm_read0), .avm_write(avm_write0), .avm_byteenable(avm_byteenable0),
    .avm_address(avm_address0), .avm_writedata(avm_writedata0),
    .avm_readdata(avm_readdata0), .avm_waitrequest(avm_waitrequest0)
  );

  avalon_mem_arbiter #(.ROUND_ROBIN(1)) dut1 (
    .clk(clk), .reset(rst_n),
    .i_read(i_read1), .i_address(i_address1), .i_readdata(i_readdata1), .i_done(i_done1),
    .d_read(d_read1), .d_write(d_write1), .d_address(d_address1),
    .d_writedata(d_writedata1), .d_byteenable(d_byteenable1),
    .d_readdata(d_readdata1), .d_done(d_done1), .err(err1),
    .avm_read(avm_read1), .avm_write(avm_write1), .avm_byteenable(avm_byteenable1),
    .avm_address(avm_address1), .avm_writedata(avm_writedata1),
    .avm_readdata(avm_readdata1), .avm_waitrequest(avm_waitrequest1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ws_cfg = 0;
  int ws_cnt = 0;
  exp_t exp_q[$];
  logic log1[$];
  logic [31:0] mem0 [16];
  logic [31:0] ref_mem [16];
  logic [31:0] d_last, i_last;
  logic        stall_q = 1'b0;
  logic [69:0] snap_q = 70'd0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Slave for dut0: memory, wait states, read latency 1, re-initialised in reset.
  assign avm_waitrequest0 = (avm_read0 | avm_write0) && (ws_cnt < ws_cfg);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!(avm_read0 | avm_write0)) ws_cnt <= 0;
    else if (avm_waitrequest0) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
    if (avm_read0 && !avm_waitrequest0) avm_readdata0 <= mem0[avm_address0[5:2]];
    else avm_readdata0 <= 32'h0BAD_0BAD;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) mem0[k] <= 32'hC0DE_0000 + 32'(k);
    end else if (avm_write0 && !avm_waitrequest0) begin
      for (int b = 0; b < 4; b++)
        if (avm_byteenable0[b]) mem0[avm_address0[5:2]][8*b +: 8] <= avm_writedata0[8*b +: 8];
    end
    stall_q <= avm_waitrequest0;
    snap_q  <= {avm_read0, avm_write0, avm_byteenable0, avm_address0, avm_writedata0};
  end

  // Slave for dut1: no wait states, returns a function of the address.
  assign avm_waitrequest1 = 1'b0;
  always @(posedge clk) begin
    avm_readdata1 <= avm_read1 ? (avm_address1 ^ 32'h5A5A_5A5A) : 32'h0BAD_0BAD;
  end

  task automatic check_done0();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_done", {i_done0, d_done0}, 2'b00);
    end else begin
      e = exp_q.pop_front();
      chk("done_port", d_done0, e.port);
      chk("done_single", i_done0 & d_done0, 1'b0);
      chk("done_err", err0, e.err);
      chk("done_data", e.port ? d_readdata0 : i_readdata0, e.data);
      chk("done_cycle", cyc, e.due);
    end
  endtask

  task automatic check_done1();
    log1.push_back(d_done1);
    if (d_done1) chk("rr_ddata", d_readdata1, d_address1 ^ 32'h5A5A_5A5A);
    else chk("rr_idata", i_readdata1, i_address1 ^ 32'h5A5A_5A5A);
  endtask

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (avm_read0 | avm_write0 | avm_read1 | avm_write1)
        chk("rd_wr_exclusive", (avm_read0 & avm_write0) | (avm_read1 & avm_write1), 1'b0);
      if (stall_q)
        chk("avm_stable", {avm_read0, avm_write0, avm_byteenable0, avm_address0, avm_writedata0}, snap_q);
      if (i_done0 | d_done0) check_done0();
      if (i_done1 | d_done1) check_done1();
    end
  end

  task automatic init_ref();
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'hC0DE_0000 + 32'(k);
    d_last = 32'h0;
    i_last = 32'h0;
  endtask

  task automatic d_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int lat, input logic glitch,
                       output int n_rd, output int n_wr);
    exp_t e;
    logic mis;
    logic got;
    logic [31:0] data;
    @(negedge clk);
    mis = (a[1:0] != 2'b00);
    got = 1'b0;
    n_rd = 0;
    n_wr = 0;
    if (mis) begin
      data = d_last;
    end else if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
      data = d_last;
    end else begin
      data = ref_mem[a[5:2]];
      d_last = data;
    end
    e.port = 1'b1; e.err = mis; e.data = data; e.due = cyc + lat;
    exp_q.push_back(e);
    d_read0 = ~wr; d_write0 = wr; d_address0 = a; d_writedata0 = wd; d_byteenable0 = be;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (glitch && k == 0) begin
        d_address0 = a ^ 32'h0000_0004; d_writedata0 = ~wd; d_byteenable0 = ~be;
      end
      if (avm_read0) n_rd++;
      if (avm_write0) n_wr++;
      if (d_done0) begin got = 1'b1; break; end
    end
    chk("d_timeout", got, 1'b1);
    d_read0 = 1'b0; d_write0 = 1'b0;
  endtask

  initial begin
    int n_rd, n_wr;
    logic got;
    exp_t e;
    rst_n = 1'b0;
    {i_read0, d_read0, d_write0, i_read1, d_read1, d_write1} = 6'b0;
    i_address0 = 32'h0; d_address0 = 32'h0; d_writedata0 = 32'h0; d_byteenable0 = 4'h0;
    i_address1 = 32'h0000_0100; d_address1 = 32'h0000_0200;
    d_writedata1 = 32'h0; d_byteenable1 = 4'hF;
    init_ref();
    repeat (3) @(negedge clk);
    chk("reset_avm", {avm_read0, avm_write0, avm_byteenable0, avm_address0, avm_writedata0}, 70'd0);
    chk("reset_done", {i_done0, d_done0, err0, i_done1, d_done1, err1}, 6'b0);
    chk("reset_rdata", {i_readdata0, d_readdata0}, 64'd0);
    rst_n = 1'b1;

    // Round robin with both ports requesting continuously: I, D, I, D.
    @(negedge clk);
    i_read1 = 1'b1; d_read1 = 1'b1;
    repeat (14) @(negedge clk);
    i_read1 = 1'b0; d_read1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("rr_count_ge4", log1.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++)
      if (k < log1.size()) chk("rr_order", log1[k], (k % 2) == 1);

    // Partial write then read-back, no wait states.
    d_req(1'b1, 32'hBFC0_0010, 32'hDEAD_BEEF, 4'b0011, 2, 1'b0, n_rd, n_wr);
    chk("wr_pulse_cycles", n_wr, 1);
    chk("wr_no_read", n_rd, 0);
    d_req(1'b0, 32'hBFC0_0010, 32'h0, 4'hF, 3, 1'b0, n_rd, n_wr);
    chk("rd_merge", d_readdata0, 32'hC0DE_BEEF);

    // Contention with fixed priority: data at cycle 3, instruction at cycle 6.
    @(negedge clk);
    e.port = 1'b1; e.err = 1'b0; e.data = ref_mem[1]; e.due = cyc + 3;
    exp_q.push_back(e);
    d_last = ref_mem[1];
    e.port = 1'b0; e.err = 1'b0; e.data = ref_mem[0]; e.due = cyc + 6;
    exp_q.push_back(e);
    i_last = ref_mem[0];
    i_read0 = 1'b1; i_address0 = 32'hBFC0_0000;
    d_read0 = 1'b1; d_address0 = 32'hBFC0_0004; d_byteenable0 = 4'hF;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_done0) d_read0 = 1'b0;
      if (i_done0) begin got = 1'b1; break; end
    end
    chk("contend_timeout", got, 1'b1);
    i_read0 = 1'b0; d_read0 = 1'b0;

    // Three wait states on a read.
    ws_cfg = 3;
    d_req(1'b0, 32'hBFC0_0008, 32'h0, 4'hF, 6, 1'b0, n_rd, n_wr);
    chk("wait_read_cycles", n_rd, 4);
    ws_cfg = 0;
    chk("i_rdata_hold", i_readdata0, i_last);

    // Misaligned read and write: immediate err, no bus cycle.
    d_req(1'b0, 32'hBFC0_0002, 32'h0, 4'hF, 1, 1'b0, n_rd, n_wr);
    chk("mis_rd_nobus", n_rd + n_wr, 0);
    d_req(1'b1, 32'hBFC0_0021, 32'h1111_2222, 4'hF, 1, 1'b0, n_rd, n_wr);
    chk("mis_wr_nobus", n_rd + n_wr, 0);

    // Inputs changed after the grant must not affect the write.
    ws_cfg = 2;
    d_req(1'b1, 32'hBFC0_0014, 32'h1234_5678, 4'b1111, 4, 1'b1, n_rd, n_wr);
    ws_cfg = 0;
    d_req(1'b0, 32'hBFC0_0014, 32'h0, 4'hF, 3, 1'b0, n_rd, n_wr);
    d_req(1'b0, 32'hBFC0_0018, 32'h0, 4'hF, 3, 1'b0, n_rd, n_wr);

    // Reset while waiting in BUS, then re-issue.
    ws_cfg = 6;
    @(negedge clk);
    d_read0 = 1'b1; d_address0 = 32'hBFC0_000C; d_byteenable0 = 4'hF;
    repeat (2) @(negedge clk);
    chk("bus_before_reset", avm_read0, 1'b1);
    rst_n = 1'b0;
    d_read0 = 1'b0;
    #1;
    chk("reset_async_read", {avm_read0, avm_write0}, 2'b00);
    chk("reset_no_done", {i_done0, d_done0, err0}, 3'b000);
    repeat (3) @(negedge clk);
    chk("reset_rdata_clear", {i_readdata0, d_readdata0}, 64'd0);
    ws_cfg = 0;
    init_ref();
    rst_n = 1'b1;
    d_req(1'b0, 32'hBFC0_000C, 32'h0, 4'hF, 3, 1'b0, n_rd, n_wr);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
